// File: rtl/seg_scan_if.sv
`timescale 1ns/1ps
// seg_scan_if
// Bundles the value-source side and the decoder/display side of the
// seven-segment scan controller.
//
// Signals:
//   load       value source -> controller: capture bcd_in this cycle
//   bcd_in     value source -> controller: new BCD word, digit k at [4k+3:4k]
//   lz_sup     value source -> controller: leading-zero suppression (live)
//   bcd_out    controller -> decoder: BCD digit currently presented
//   digit_en   controller -> display: one-hot digit drive, zero in gaps
//   blank      controller -> decoder: 1 forces segments dark
//   frame_done controller -> source: one-cycle pulse at each frame wrap
//   pending    controller -> source: shadow holds a value not yet shown
//   state_dbg  controller -> observer: 0 = GAP, 1 = DRIVE
//
// Handshake: load is a single-cycle strobe with no back-pressure. Every
// cycle with load=1 is accepted; a later load before the frame wrap simply
// replaces the earlier one. pending reports whether an accepted value is
// still waiting for the wrap.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    lz_sup;
    logic [3:0]              bcd_out;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank;
    logic                    frame_done;
    logic                    pending;
    logic                    state_dbg;

    modport master (
        output load, bcd_in, lz_sup,
        input  bcd_out, digit_en, blank, frame_done, pending, state_dbg
    );

    modport slave (
        input  load, bcd_in, lz_sup,
        output bcd_out, digit_en, blank, frame_done, pending, state_dbg
    );
endinterface

// File: rtl/seg_scan_controller.sv
`timescale 1ns/1ps
// seg_scan_controller
// Time-multiplexes one BCD-to-7-segment decoder across NUM_DIGITS digit
// positions. Each digit slot is DEAD blanking cycles (GAP) followed by
// REFRESH_DIV drive cycles (DRIVE). New values land in a shadow register
// and are only copied into the displayed word at the frame wrap, so one
// frame never mixes old and new digits.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    seg_scan_if slave modport (load/bcd_in/lz_sup in; bcd_out,
//          digit_en, blank, frame_done, pending, state_dbg out)
module seg_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int DEAD        = 2
) (
    input  logic          clk,
    input  logic          reset,
    seg_scan_if.slave     bus
);
    localparam int CNT_MAX = (REFRESH_DIV > DEAD) ? REFRESH_DIV : DEAD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);
    localparam int WW      = 4 * NUM_DIGITS;

    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   display;
    logic [WW-1:0]   shadow;

    logic            last_idx;
    logic [IW-1:0]   idx_next;
    logic [WW-1:0]   wrap_word;
    logic [3:0]      cur_digit;
    logic            upper_zero;
    logic            blank_drive;

    assign bus.state_dbg = (state == DRIVE);

    always_comb begin
        last_idx  = (idx == IW'(NUM_DIGITS - 1));
        idx_next  = last_idx ? '0 : idx + IW'(1);
        // A load on the wrap cycle beats whatever stale value sits in shadow.
        wrap_word = bus.load ? bus.bcd_in : (bus.pending ? shadow : display);
        cur_digit = display[4*int'(idx) +: 4];

        // Digit idx and everything above it are zero -> candidate for suppression.
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && display[4*k +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end

        // Digit 0 is never suppressed so a zero value still reads "0".
        blank_drive = (cur_digit > 4'd9) ||
                      (bus.lz_sup && (idx != '0) && upper_zero);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= GAP;
            idx            <= '0;
            cnt            <= '0;
            display        <= '0;
            shadow         <= '0;
            bus.bcd_out    <= 4'd0;
            bus.digit_en   <= '0;
            bus.blank      <= 1'b1;
            bus.frame_done <= 1'b0;
            bus.pending    <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;

            if (bus.load) begin
                shadow      <= bus.bcd_in;
                bus.pending <= 1'b1;
            end

            case (state)
                GAP: begin
                    bus.digit_en <= '0;
                    bus.blank    <= 1'b1;
                    if (cnt == CW'(DEAD - 1)) begin
                        state        <= DRIVE;
                        cnt          <= '0;
                        bus.digit_en <= NUM_DIGITS'(1) << idx;
                        bus.blank    <= blank_drive;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DRIVE: begin
                    // Re-evaluated every cycle so lz_sup acts live.
                    bus.blank <= blank_drive;
                    if (cnt == CW'(REFRESH_DIV - 1)) begin
                        state        <= GAP;
                        cnt          <= '0;
                        bus.digit_en <= '0;
                        bus.blank    <= 1'b1;
                        idx          <= idx_next;
                        if (last_idx) begin
                            // Frame wrap: commit the next word and present its digit 0.
                            display        <= wrap_word;
                            bus.pending    <= 1'b0;
                            bus.frame_done <= 1'b1;
                            bus.bcd_out    <= wrap_word[3:0];
                        end else begin
                            bus.bcd_out <= display[4*int'(idx_next) +: 4];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= GAP;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seg_scan_controller.sv
`timescale 1ns/1ps
// Directed bench for seg_scan_controller with NUM_DIGITS=4, REFRESH_DIV=4,
// DEAD=1 (digit slot 5 cycles, frame 20 cycles). Frame position q counts
// edges from the wrap edge (q=0) to q=19; digit d occupies q=5d..5d+4 with
// q=5d being its blanking gap.
module tb_seg_scan_controller;
    logic clk;
    logic reset;

    int n_cmp;
    int n_err;
    int cur_q;

    // Expected digit_en per frame position, written out by hand.
    int en_tbl [20] = '{0, 1, 1, 1, 1,
                        0, 2, 2, 2, 2,
                        0, 4, 4, 4, 4,
                        0, 8, 8, 8, 8};

    seg_scan_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_controller #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .DEAD        (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Driver / check tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s q=%0d observed=%0h expected=%0h", tag, cur_q, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".bcd_out"},    32'(bus.bcd_out),    32'd0);
        chk({tag, ".digit_en"},   32'(bus.digit_en),   32'd0);
        chk({tag, ".blank"},      32'(bus.blank),      32'd1);
        chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'd0);
        chk({tag, ".pending"},    32'(bus.pending),    32'd0);
        chk({tag, ".state"},      32'(bus.state_dbg),  32'd0);
    endtask

    // Runs frame positions q_start..q_end. disp is the word expected on
    // screen for this frame, bmask the per-digit blank value in DRIVE
    // (bit d = digit d). Loads are issued so they are sampled at edge lq1/lq2.
    task automatic run_frame(input int q_start, input int q_end,
                             input logic [15:0] disp, input logic lz,
                             input logic [3:0] bmask,
                             input int lq1, input logic [15:0] lv1,
                             input int lq2, input logic [15:0] lv2);
        int pend_from;
        int d;
        logic [15:0] dw;
        dw = disp;
        pend_from = (lq1 > 0) ? lq1 : ((lq2 > 0) ? lq2 : 100);
        bus.lz_sup = lz;
        for (int q = q_start; q <= q_end; q++) begin
            if (q == lq1) begin
                bus.load   = 1'b1;
                bus.bcd_in = lv1;
            end else if (q == lq2) begin
                bus.load   = 1'b1;
                bus.bcd_in = lv2;
            end else begin
                bus.load = 1'b0;
            end
            tick();
            cur_q = q;
            d = q / 5;
            chk("digit_en",   32'(bus.digit_en),   32'(en_tbl[q]));
            chk("frame_done", 32'(bus.frame_done), (q == 0) ? 32'd1 : 32'd0);
            chk("bcd_out",    32'(bus.bcd_out),    32'(dw[4*d +: 4]));
            chk("blank",      32'(bus.blank),      (q % 5 == 0) ? 32'd1 : 32'(bmask[d]));
            chk("pending",    32'(bus.pending),    (q >= pend_from) ? 32'd1 : 32'd0);
            chk("state",      32'(bus.state_dbg),  (q % 5 != 0) ? 32'd1 : 32'd0);
        end
        bus.load = 1'b0;
    endtask

    // Directed sequence
    initial begin
        n_cmp      = 0;
        n_err      = 0;
        cur_q      = -1;
        reset      = 1'b1;
        bus.load   = 1'b0;
        bus.bcd_in = 16'h0000;
        bus.lz_sup = 1'b0;

        tick();
        tick();
        chk_reset_values("reset");
        reset = 1'b0;

        // Frame 0 after reset: zero word, no suppression, digit 0 drives first.
        run_frame(1, 19, 16'h0000, 1'b0, 4'b0000, -1, 16'h0, -1, 16'h0);

        // Zero word with suppression: digits 1..3 dark, digit 0 shown.
        // 1234 loaded mid-frame must not appear before the wrap.
        run_frame(0, 19, 16'h0000, 1'b1, 4'b1110, 7, 16'h1234, -1, 16'h0);

        // 1234 on screen; two loads, the second must win.
        run_frame(0, 19, 16'h1234, 1'b0, 4'b0000, 3, 16'h1111, 12, 16'h5678);

        // 5678 on screen (1111 never shown); suppression leaves nonzero digits.
        // A stale 3333 sits in shadow going into the wrap.
        run_frame(0, 19, 16'h5678, 1'b1, 4'b0000, 15, 16'h3333, -1, 16'h0);

        // 0042 loaded on the wrap edge beats the stale shadow; pending stays 0.
        run_frame(0, 19, 16'h0042, 1'b1, 4'b1100, 0, 16'h0042, 18, 16'h9A0F);

        // 9A0F: digits F and A dark, 0 and 9 shown. Stop in DRIVE of digit 2
        // with 7777 pending.
        run_frame(0, 12, 16'h9A0F, 1'b0, 4'b0101, 3, 16'h7777, -1, 16'h0);

        reset = 1'b1;
        tick();
        cur_q = -2;
        chk_reset_values("mid_reset");
        reset = 1'b0;

        // Scan restarts at digit 0; the discarded 7777 never reaches the display.
        run_frame(1, 19, 16'h0000, 1'b0, 4'b0000, -1, 16'h0, -1, 16'h0);
        run_frame(0, 4,  16'h0000, 1'b0, 4'b0000, -1, 16'h0, -1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexing scan controller that shares a single BCD-to-7-segment decoder across NUM_DIGITS common-anode/cathode digit positions. It holds a displayed BCD word, presents one digit at a time on the decoder inputs, drives a one-hot digit enable, and inserts blanking gaps between digits to prevent ghosting. New values are loaded into a shadow register and applied only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the value source (counter/ALU result) and the BCD_to_7segment decoder feeding the board display.

## Interface
- NUM_DIGITS, 4, number of digit positions scanned (≥2)
- REFRESH_DIV, 1000, clock cycles each digit is driven (≥1)
- DEAD, 2, blanking cycles before each digit is driven (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- load  input  1  capture bcd_in into shadow register this cycle
- bcd_in  input  4*NUM_DIGITS  new value; digit k = bcd_in[4k+3:4k], digit 0 least significant
- lz_sup  input  1  leading-zero suppression enable (sampled live)
- bcd_out  output  4  to decoder D3..D0 = bcd_out[3:0]
- digit_en  output  NUM_DIGITS  one-hot digit drive, active-high; all-zero during gaps
- blank  output  1  1 = force segments dark
- frame_done  output  1  one-cycle pulse at end of each frame
- pending  output  1  shadow holds a value not yet displayed

## Operation
- All outputs registered. Reset values: bcd_out=0, digit_en=0, blank=1, frame_done=0, pending=0; internal display word=0, shadow=0, idx=0, cnt=0, state=GAP.
- FSM states: GAP, DRIVE.
  - GAP: digit_en=0, blank=1, bcd_out=display digit idx. After DEAD cycles -> DRIVE, cnt cleared.
  - DRIVE: digit_en[idx]=1, others 0; blank per rules below. After REFRESH_DIV cycles -> GAP with idx+1; if idx=NUM_DIGITS-1, idx wraps to 0 (frame wrap).
- blank in DRIVE = 1 if digit value >9 (invalid BCD), or lz_sup=1 and the digit and all higher digits are 0 and idx≠0; else 0. Digit 0 is never zero-suppressed (value 0 shows "0").
- Load: load=1 writes bcd_in to shadow, pending=1. Repeated loads before wrap overwrite shadow (last wins).
- Frame wrap cycle: if pending, display<=shadow, pending<=0; frame_done=1 for that cycle.
- load on the wrap cycle: bcd_in goes directly to display, pending=0 (load wins over stale shadow).
- reset mid-frame: returns to reset values on next edge regardless of state; shadow contents discarded.
- Counters sized $clog2 of their limits; no overflow beyond limits.

## Timing
- Digit period = DEAD+REFRESH_DIV cycles; frame = NUM_DIGITS*(DEAD+REFRESH_DIV) cycles.
- Edge n = nth rising edge with reset low (n=1 first). GAP for digit 0 spans reset and edges 1..DEAD-1; digit_en[0] rises after edge DEAD, stays high REFRESH_DIV cycles.
- bcd_out changes at the start of GAP, DEAD ≥1 cycles before digit_en asserts; bcd_out is stable throughout DRIVE.
- Load-to-display latency: up to one frame; new digit 0 appears on bcd_out in the cycle after the wrap edge.
- frame_done asserted in the same cycle idx returns to 0 and state enters GAP.
- digit_en never has more than one bit set; never set in the same cycle as a change of bcd_out.

## Test plan
Parameters NUM_DIGITS=4, REFRESH_DIV=4, DEAD=1 (digit period 5, frame 20 cycles).
- Reset release, no load -> digit_en sequence 0,0001x4,0,0010x4,0,0100x4,0,1000x4, repeating; bcd_out=0; frame_done every 20 cycles; digit 0 unblanked, with lz_sup=1 digits 1-3 blank=1.
- load bcd_in=16'h1234 mid-frame -> pending=1 until wrap; next frame bcd_out 4,3,2,1 on digit_en 0001,0010,0100,1000; current frame unchanged.
- Two loads (16'h1111 then 16'h5678) in one frame -> next frame shows 8,7,6,5 only; 1111 never displayed.
- load 16'h0042 on the wrap cycle -> display updated immediately, pending=0; lz_sup=1 -> digits 3,2 blank, digits 1,0 show 4,2.
- bcd_in=16'h9A0F -> digits with values F and A blank=1 in DRIVE; digits 9 and 0 shown.
- reset asserted during DRIVE of digit 2 with pending=1 -> next cycle digit_en=0, blank=1, pending=0, bcd_out=0; scan restarts at digit 0 after DEAD.
